// File: rtl/iir_pkg.sv
// Shared constants for the IIR coefficient loader: register addresses,
// FSM state encoding, default widths and a reference saturate helper.
package iir_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_COEFF_W = 16;

  localparam logic [2:0] ADDR_B0   = 3'd0;
  localparam logic [2:0] ADDR_B1   = 3'd1;
  localparam logic [2:0] ADDR_B2   = 3'd2;
  localparam logic [2:0] ADDR_A1   = 3'd3;
  localparam logic [2:0] ADDR_A2   = 3'd4;
  localparam logic [2:0] ADDR_GAIN = 3'd5;

  localparam int NUM_COEFF = 6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  // Clamp a default-width GPIO word into the default coefficient range.
  function automatic logic signed [DEF_COEFF_W-1:0] saturate(
    input logic signed [DEF_IN_W-1:0] d
  );
    logic signed [DEF_IN_W-1:0] hi;
    logic signed [DEF_IN_W-1:0] lo;
    hi = DEF_IN_W'((64'sd1 <<< (DEF_COEFF_W-1)) - 64'sd1);
    lo = -hi - DEF_IN_W'(1);
    if (d > hi)
      return {1'b0, {(DEF_COEFF_W-1){1'b1}}};
    else if (d < lo)
      return {1'b1, {(DEF_COEFF_W-1){1'b0}}};
    else
      return d[DEF_COEFF_W-1:0];
  endfunction

endpackage

// File: rtl/coeff_sat.sv
// Combinational signed saturator, IN_W -> OUT_W, with overflow flag.
// Ports: din (signed IN_W), dout (signed OUT_W), ovf (1 = clamped).
module coeff_sat
  import iir_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_COEFF_W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // Value fits iff all bits from the output sign bit upward agree.
  logic [IN_W-OUT_W:0] hi;

  always_comb begin
    hi  = din[IN_W-1:OUT_W-1];
    ovf = !((&hi) || !(|hi));
    if (!ovf)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/iir_coeff_loader.sv
// Shadow/active coefficient bank for a biquad: saturating writes, atomic
// apply on sample_stb or timeout. Optional stability check: macro
// IIR_COEFF_STABILITY_CHECK_EN.
// Ports: clk, rst (async high); wr_en/wr_addr/wr_data shadow write;
// commit, sample_stb, clr_status; b0..gain_out active set;
// coeff_updated, busy, sat_flag, wr_err, timeout_flag, reject.
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int IN_COEFF_WIDTH = DEF_IN_W,
  parameter int COEFF_WIDTH    = DEF_COEFF_W,
  parameter int LOG_A0         = COEFF_WIDTH - 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [2:0]                       wr_addr,
  input  logic signed [IN_COEFF_WIDTH-1:0] wr_data,
  input  logic                             commit,
  input  logic                             sample_stb,
  input  logic                             clr_status,
  output logic signed [COEFF_WIDTH-1:0]    b0_out,
  output logic signed [COEFF_WIDTH-1:0]    b1_out,
  output logic signed [COEFF_WIDTH-1:0]    b2_out,
  output logic signed [COEFF_WIDTH-1:0]    a1_out,
  output logic signed [COEFF_WIDTH-1:0]    a2_out,
  output logic signed [COEFF_WIDTH-1:0]    gain_out,
  output logic                             coeff_updated,
  output logic                             busy,
  output logic                             sat_flag,
  output logic                             wr_err,
  output logic                             timeout_flag,
  output logic                             reject
);

  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [CNT_W-1:0] cnt;

  logic signed [COEFF_WIDTH-1:0] shadow [NUM_COEFF];
  logic signed [COEFF_WIDTH-1:0] active [NUM_COEFF];

  logic signed [COEFF_WIDTH-1:0] sat_data;
  logic sat_ovf;

  logic idle;
  logic addr_ok;
  logic wr_ok;
  logic bad_wr;
  logic bad_commit;
  logic tmo_hit;
  logic apply;
  logic forced;
  logic chk_fail;

  coeff_sat #(
    .IN_W  (IN_COEFF_WIDTH),
    .OUT_W (COEFF_WIDTH)
  ) u_sat (
    .din  (wr_data),
    .dout (sat_data),
    .ovf  (sat_ovf)
  );

  assign idle       = (state == ST_IDLE);
  assign addr_ok    = (wr_addr <= ADDR_GAIN);
  assign wr_ok      = wr_en && idle && addr_ok;
  assign bad_wr     = wr_en && !(idle && addr_ok);
  assign bad_commit = commit && !idle;
  // TIMEOUT_CYCLES == 0 disables the forced apply entirely.
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) &&
                      (cnt == CNT_W'(TMO_LAST));

`ifdef IIR_COEFF_STABILITY_CHECK_EN
  localparam int XW = COEFF_WIDTH + 2;

  logic signed [XW-1:0] a0x;
  logic signed [XW-1:0] a1x;
  logic signed [XW-1:0] a2x;
  logic signed [XW-1:0] a1abs;
  logic signed [XW-1:0] a2abs;
  logic stable;

  // Extra headroom so |min| and A0 + a2 cannot wrap.
  always_comb begin
    a0x    = XW'(64'sd1 <<< LOG_A0);
    a1x    = XW'(shadow[ADDR_A1]);
    a2x    = XW'(shadow[ADDR_A2]);
    a1abs  = a1x[XW-1] ? -a1x : a1x;
    a2abs  = a2x[XW-1] ? -a2x : a2x;
    stable = (a2abs < a0x) && (a1abs < (a0x + a2x));
  end
`endif

  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    forced    = 1'b0;
    chk_fail  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) begin
`ifdef IIR_COEFF_STABILITY_CHECK_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_PENDING;
`endif
        end
      end
`ifdef IIR_COEFF_STABILITY_CHECK_EN
      ST_CHECK: begin
        if (stable) begin
          state_nxt = ST_PENDING;
        end else begin
          state_nxt = ST_IDLE;
          chk_fail  = 1'b1;
        end
      end
`endif
      ST_PENDING: begin
        if (sample_stb || tmo_hit) begin
          apply     = 1'b1;
          forced    = !sample_stb;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      // Counter is zero whenever PENDING is entered.
      if (state != ST_PENDING)
        cnt <= '0;
      else if (!apply)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_ok)
        shadow[wr_addr] <= sat_data;
      if (apply) begin
        for (int i = 0; i < NUM_COEFF; i++)
          active[i] <= shadow[i];
      end
    end
  end

  // Sticky flags: a set in the same cycle as clr_status wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff_updated <= 1'b0;
      sat_flag      <= 1'b0;
      wr_err        <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      coeff_updated <= apply;
      sat_flag      <= (wr_ok && sat_ovf) ||
                       (sat_flag && !clr_status);
      wr_err        <= bad_wr || bad_commit ||
                       (wr_err && !clr_status);
      timeout_flag  <= forced ||
                       (timeout_flag && !clr_status);
    end
  end

`ifdef IIR_COEFF_STABILITY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      reject <= 1'b0;
    else
      reject <= chk_fail;
  end
`else
  assign reject = 1'b0;
`endif

  assign b0_out   = active[ADDR_B0];
  assign b1_out   = active[ADDR_B1];
  assign b2_out   = active[ADDR_B2];
  assign a1_out   = active[ADDR_A1];
  assign a2_out   = active[ADDR_A2];
  assign gain_out = active[ADDR_GAIN];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader (default build, TIMEOUT_CYCLES=16).
// Committed sets are queued and compared on each coeff_updated pulse.
module tb_iir_coeff_loader;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [2:0] wr_addr;
  logic signed [31:0] wr_data;
  logic commit;
  logic sample_stb;
  logic clr_status;
  logic signed [15:0] b0_out, b1_out, b2_out;
  logic signed [15:0] a1_out, a2_out, gain_out;
  logic coeff_updated, busy, sat_flag;
  logic wr_err, timeout_flag, reject;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] sh [6];
  logic [95:0] exp_q [$];

  iir_coeff_loader #(
    .IN_COEFF_WIDTH (32),
    .COEFF_WIDTH    (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .sample_stb    (sample_stb),
    .clr_status    (clr_status),
    .b0_out        (b0_out),
    .b1_out        (b1_out),
    .b2_out        (b2_out),
    .a1_out        (a1_out),
    .a2_out        (a2_out),
    .gain_out      (gain_out),
    .coeff_updated (coeff_updated),
    .busy          (busy),
    .sat_flag      (sat_flag),
    .wr_err        (wr_err),
    .timeout_flag  (timeout_flag),
    .reject        (reject)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] sat16(input longint v);
    logic [63:0] t;
    if (v > 32767) return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [95:0] model_set();
    return {sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d, input bit upd);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (upd) sh[a] = sat16(d);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    exp_q.push_back(model_set());
  endtask

  task automatic strobe();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  // Every apply must match the oldest outstanding committed set.
  always @(negedge clk) begin
    if (coeff_updated) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_update observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        logic [95:0] e;
        logic [95:0] o;
        e = exp_q.pop_front();
        o = {b0_out, b1_out, b2_out, a1_out, a2_out, gain_out};
        tests++;
        assert (o === e) else begin
          fails++;
          $error("FAIL applied_set observed=%h expected=%h", o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit = 1'b0;
    sample_stb = 1'b0;
    clr_status = 1'b0;
    for (int i = 0; i < 6; i++) sh[i] = '0;
    repeat (2) tick();
    chk("rst_b0", b0_out, 0);
    chk("rst_gain", gain_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {sat_flag, wr_err, timeout_flag}, 0);
    chk("rst_pulses", {coeff_updated, reject}, 0);
    rst = 1'b0;
    tick();

    // Basic apply on strobe 5 cycles after commit.
    wr(0, 16384, 1);
    do_commit();
    chk("t1_busy", busy, 1);
    chk("t1_hold0", b0_out, 0);
    repeat (4) begin
      tick();
      chk("t1_hold", b0_out, 0);
      chk("t1_busy_wait", busy, 1);
    end
    strobe();
    chk("t1_b0", b0_out, 16384);
    chk("t1_upd", coeff_updated, 1);
    chk("t1_busy_done", busy, 0);
    tick();
    chk("t1_upd_end", coeff_updated, 0);

    // Saturation both directions, clear, set-wins-over-clear.
    wr(3, 100000, 1);
    wr(4, -70000, 1);
    chk("t2_sat", sat_flag, 1);
    do_commit();
    tick();
    strobe();
    chk("t2_a1", a1_out, 32767);
    chk("t2_a2", a2_out, -32768);
    chk("t2_b0_kept", b0_out, 16384);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t2_clr", sat_flag, 0);
    clr_status = 1'b1;
    wr(3, 40000, 1);
    clr_status = 1'b0;
    chk("t2_setwins", sat_flag, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t2_clr2", sat_flag, 0);

    // Forced apply after 16 cycles in PENDING.
    wr(2, -1234, 1);
    do_commit();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (coeff_updated && k == 0) k = i;
    end
    chk("t3_latency", k, 16);
    chk("t3_tmo", timeout_flag, 1);
    chk("t3_b2", b2_out, -1234);
    chk("t3_idle", busy, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t3_tmo_clr", timeout_flag, 0);

    // Strobe coincident with commit does not apply.
    wr(5, 777, 1);
    commit = 1'b1;
    sample_stb = 1'b1;
    tick();
    commit = 1'b0;
    sample_stb = 1'b0;
    exp_q.push_back(model_set());
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_noapply", coeff_updated, 0);
    chk("t4_gain_hold", gain_out, 0);
    strobe();
    chk("t4_apply", coeff_updated, 1);
    chk("t4_gain", gain_out, 777);
    chk("t4_tmo", timeout_flag, 0);

    // Write and commit while busy are dropped.
    wr(1, 7, 1);
    do_commit();
    wr(1, 5, 0);
    chk("t5_wr_err", wr_err, 1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    strobe();
    chk("t5_b1", b1_out, 7);
    tick();
    chk("t5_idle", busy, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t5_clr", wr_err, 0);

    // Invalid address, set-wins on wr_err, same-cycle write+commit.
    wr(6, 999, 0);
    chk("t6_badaddr", wr_err, 1);
    clr_status = 1'b1;
    wr(7, 1, 0);
    clr_status = 1'b0;
    chk("t6_setwins", wr_err, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t6_clr", wr_err, 0);
    wr_en = 1'b1;
    wr_addr = 3'd2;
    wr_data = -3;
    commit = 1'b1;
    tick();
    wr_en = 1'b0;
    commit = 1'b0;
    sh[2] = -16'sd3;
    exp_q.push_back(model_set());
    chk("t6_nowerr", wr_err, 0);
    strobe();
    chk("t6_b2", b2_out, -3);

    // Reset in PENDING drops the commit.
    wr(5, 123, 1);
    do_commit();
    tick();
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    for (int i = 0; i < 6; i++) sh[i] = '0;
    chk("t7_b0", b0_out, 0);
    chk("t7_a1", a1_out, 0);
    chk("t7_gain", gain_out, 0);
    chk("t7_busy", busy, 0);
    chk("t7_flags", {sat_flag, wr_err, timeout_flag}, 0);
    tick();
    rst = 1'b0;
    strobe();
    chk("t7_noupd", coeff_updated, 0);
    repeat (20) tick();
    chk("t7_noupd2", coeff_updated, 0);
    chk("t7_gain2", gain_out, 0);
    chk("t7_busy2", busy, 0);
    chk("t7_reject", reject, 0);
    chk("q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Coefficient staging block directly upstream of the 2nd-order IIR stage.
- Software writes 32-bit pre-scaled GPIO words into a shadow bank. Each word is saturated down to COEFF_WIDTH.
- On commit, the whole set (b0, b1, b2, a1, a2, gain) transfers atomically to the active outputs at a sample boundary. The filter therefore never runs a half-updated coefficient set.

Parameters:
IN_COEFF_WIDTH, 32, width of GPIO data word (signed)
COEFF_WIDTH, 16, width of active coefficient outputs (signed)
LOG_A0, COEFF_WIDTH-2, fixed-point scale exponent; A0 = 2**LOG_A0
TIMEOUT_CYCLES, 1024, max cycles to wait in PENDING for sample_stb before forced apply; 0 = wait forever

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  shadow write strobe, one word per cycle
wr_addr  in  3  0=b0 1=b1 2=b2 3=a1 4=a2 5=gain; 6,7 invalid
wr_data  in  IN_COEFF_WIDTH  signed coefficient word
commit  in  1  request transfer shadow -> active (pulse)
sample_stb  in  1  one-cycle strobe marking the filter sample boundary
clr_status  in  1  clears sticky flags
b0_out, b1_out, b2_out, a1_out, a2_out, gain_out  out  COEFF_WIDTH each  active coefficients to filter
coeff_updated  out  1  one-cycle pulse after each apply
busy  out  1  high while state != IDLE
sat_flag  out  1  sticky: a write was saturated
wr_err  out  1  sticky: invalid address, or write/commit while busy
timeout_flag  out  1  sticky: an apply was forced by timeout
reject  out  1  one-cycle pulse, commit refused (optional feature only)

Behaviour:
- Reset (async, rst=1):
  - All shadow and active registers become 0; all flags and pulses become 0.
  - State becomes IDLE; timeout counter is cleared.
  - Any pending commit is lost, with no coeff_updated pulse.
- Saturating write, accepted only in IDLE:
  - wr_data > 2**(COEFF_WIDTH-1)-1 stores max positive; wr_data < -2**(COEFF_WIDTH-1) stores min negative. Either case sets sat_flag.
  - Otherwise the low COEFF_WIDTH bits are stored.
  - The shadow register updates on the clock edge that samples wr_en.
- Write in IDLE to address 6 or 7: no shadow change; wr_err=1.
- States and transitions:
  - IDLE -> PENDING on commit=1 (-> CHECK when the optional feature is built).
    - Same-cycle wr_en and commit: the write lands first and is included in the commit.
  - PENDING, sample_stb=1: active outputs load from shadow on that edge; coeff_updated=1 the next cycle; -> IDLE.
    - A sample_stb in the same cycle as commit (still IDLE) does not apply; the next strobe does.
  - PENDING, counter reaches TIMEOUT_CYCLES-1 with no strobe: forced apply as above, plus timeout_flag=1.
    - The counter clears on entering PENDING.
- While busy:
  - wr_en is dropped and sets wr_err; shadow is unchanged.
  - commit is ignored and sets wr_err.
- Outputs change only on apply. Between applies they hold; the filter sees a constant set.
- clr_status clears sat_flag, wr_err and timeout_flag. If a set event occurs in the same cycle, the set wins.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: IIR_COEFF_STABILITY_CHECK_EN
- Defined:
  - commit moves IDLE -> CHECK for one cycle.
  - CHECK tests the stability triangle on shadow values: |a2| < A0 and |a1| < A0 + a2.
  - Pass -> PENDING.
  - Fail -> IDLE with reject=1 for one cycle; active outputs are unchanged.
- Undefined: no CHECK state; reject is tied to 0.

Decomposition:
- Package iir_pkg holds:
  - address constants ADDR_B0..ADDR_GAIN;
  - state encoding (IDLE, CHECK, PENDING);
  - default widths 32/16;
  - a saturate function (IN_COEFF_WIDTH -> COEFF_WIDTH).
- One sub-module is natural: coeff_sat. It is a combinational saturator with an overflow flag, instanced once on the write path.

Test Plan:
- Write 16384 to addr0, commit, sample_stb 5 cycles later -> b0_out = 16384 on that edge; coeff_updated pulses next cycle; busy high in between; outputs stay 0 before the strobe.
- Write 100000 to addr3 and -70000 to addr4, commit, strobe -> a1_out = 32767, a2_out = -32768, sat_flag = 1; clr_status -> sat_flag = 0.
- TIMEOUT_CYCLES = 16, commit, no strobe -> apply 16 cycles after entering PENDING; timeout_flag = 1; coeff_updated pulses once.
- In PENDING, write 5 to addr1 and pulse commit -> wr_err = 1; applied b1_out holds the pre-commit shadow value.
- Reset asserted mid-PENDING -> all outputs immediately 0, state IDLE, no coeff_updated; a later strobe does nothing.
- With IIR_COEFF_STABILITY_CHECK_EN: a2 = 16384, commit -> reject pulse, outputs unchanged, busy back to 0 after 2 cycles. Then a1 = 20000, a2 = 8000 -> passes and applies on the next strobe.
